instr_issue_queue: RTL and testbench

- Upstream feeder for the 8-bit pseudo-processor core.
- Buffers 20-bit instruction words written by a loader (file reader, UART or boot ROM) in an internal FIFO.
- Once started, presents one word per clock on the core's `data` input.
- Inserts NOP bubbles when starved and signals completion once the program has drained.

---
 rtl/instr_issue_queue.sv | 122 ++++++++++++
 tb/tb_instr_issue_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - instruction FIFO that issues one word per clock to the core, with NOP bubbles and completion status
module instr_issue_queue #(
  parameter int          DEPTH    = 8,
  parameter int          ADDR_W   = 3,
  parameter logic [19:0] NOP_WORD = 20'h00000,
  parameter int          CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [19:0]      wr_data,
  input  logic             load_done,
  input  logic             start,
  output logic             full,
  output logic             overflow,
  output logic [19:0]      data,
  output logic             data_valid,
  output logic [CNT_W-1:0] issue_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [19:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [19:0]       r_data;
  logic              r_data_valid;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic              r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_clr_cnt;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_pop     = (r_state == S_RUN) && !w_empty;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign w_push    = wr_en && (!w_full || w_pop);
  assign w_clr_cnt = start && (r_state != S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN:  if (w_empty && load_done) w_state_nxt = S_DONE;
      S_DONE: if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= NOP_WORD;
      r_data_valid <= 1'b0;
      r_issue_cnt  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (wr_en && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_pop) begin
        r_data       <= r_mem[r_rd_ptr];
        r_data_valid <= 1'b1;
        r_issue_cnt  <= r_issue_cnt + CNT_W'(1);
      end else begin
        r_data       <= NOP_WORD;
        r_data_valid <= 1'b0;
        if (w_clr_cnt) r_issue_cnt <= '0;
      end
    end
  end

  assign full        = w_full;
  assign overflow    = r_overflow;
  assign data        = r_data;
  assign data_valid  = r_data_valid;
  assign issue_count = r_issue_cnt;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_issue_queue.sv
// tb/tb_instr_issue_queue.sv - self-checking bench for instr_issue_queue
module tb_instr_issue_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [19:0] wr_data = '0;
  logic        load_done = 1'b0;
  logic        start = 1'b0;
  logic        full;
  logic        overflow;
  logic [19:0] data;
  logic        data_valid;
  logic [7:0]  issue_count;
  logic        busy;
  logic        done;

  instr_issue_queue #(
    .DEPTH(8), .ADDR_W(3), .NOP_WORD(20'h00000), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .load_done(load_done), .start(start), .full(full), .overflow(overflow),
    .data(data), .data_valid(data_valid), .issue_count(issue_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid word must be the oldest expected one; idle slots must carry the NOP word.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL issue_unexpected: got %h expected no issue", data);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            n_fail++;
            $display("FAIL issue_word: got %h expected %h", data, e);
          end
        end
      end else if (data !== 20'h00000) begin
        n_tests++;
        n_fail++;
        $display("FAIL bubble_word: got %h expected 00000", data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; load_done = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic write_word(input logic [19:0] w, input bit expect_issue);
    wr_en = 1'b1; wr_data = w;
    if (expect_issue) exp_q.push_back(w);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk({name, "_done_reached"}, done, 1);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [19:0] w [4];
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{name: "prog3", n: 3, w: '{20'hA1B2C, 20'h12345, 20'h0F0F0, 20'h0}, exp_cnt: 8'd3};
    vecs[1] = '{name: "prog1", n: 1, w: '{20'hFFFFF, 20'h0, 20'h0, 20'h0}, exp_cnt: 8'd1};
    vecs[2] = '{name: "prog0", n: 0, w: '{20'h0, 20'h0, 20'h0, 20'h0}, exp_cnt: 8'd0};
    vecs[3] = '{name: "prog4", n: 4, w: '{20'h00001, 20'h80000, 20'h55555, 20'hAAAAA}, exp_cnt: 8'd4};

    // Reset state
    do_reset();
    chk("rst_data", data, 20'h00000);
    chk("rst_valid", data_valid, 0);
    chk("rst_cnt", issue_count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Basic issue with exact cycle timing
    write_word(20'hA1B2C, 1'b1);
    write_word(20'h12345, 1'b1);
    write_word(20'h0F0F0, 1'b1);
    chk("basic_idle_valid", data_valid, 0);
    load_done = 1'b1;
    pulse_start();
    chk("basic_run_busy", busy, 1);
    chk("basic_lat_valid", data_valid, 0);
    tick(); chk("basic_w0", data, 20'hA1B2C); chk("basic_v0", data_valid, 1);
    tick(); chk("basic_w1", data, 20'h12345); chk("basic_v1", data_valid, 1);
    tick(); chk("basic_w2", data, 20'h0F0F0); chk("basic_v2", data_valid, 1);
    tick();
    chk("basic_end_valid", data_valid, 0);
    chk("basic_end_done", done, 1);
    chk("basic_end_cnt", issue_count, 3);

    // Table-driven programs
    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int j = 0; j < vecs[i].n; j++) write_word(vecs[i].w[j], 1'b1);
      load_done = 1'b1;
      pulse_start();
      chk({vecs[i].name, "_busy"}, busy, 1);
      wait_done(vecs[i].name);
      chk({vecs[i].name, "_cnt"}, issue_count, vecs[i].exp_cnt);
      chk({vecs[i].name, "_valid"}, data_valid, 0);
      chk({vecs[i].name, "_drained"}, exp_q.size(), 0);
    end

    // Bubble insertion while starved
    do_reset();
    write_word(20'h11111, 1'b1);
    pulse_start();
    tick(); chk("bub_w1", data, 20'h11111); chk("bub_v1", data_valid, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bub_valid", data_valid, 0);
      chk("bub_busy", busy, 1);
    end
    write_word(20'h22222, 1'b1);
    chk("bub_valid_wr", data_valid, 0);
    tick(); chk("bub_w2", data, 20'h22222); chk("bub_v2", data_valid, 1);
    chk("bub_busy2", busy, 1);
    load_done = 1'b1;
    wait_done("bub");
    chk("bub_cnt", issue_count, 2);

    // Full and overflow in IDLE
    do_reset();
    for (int k = 0; k < 8; k++) write_word(20'h30000 + 20'(k), 1'b1);
    chk("ovf_full8", full, 1);
    chk("ovf_clear8", overflow, 0);
    write_word(20'h3FFFF, 1'b0);
    chk("ovf_set9", overflow, 1);
    chk("ovf_full9", full, 1);
    load_done = 1'b1;
    pulse_start();
    wait_done("ovf");
    chk("ovf_cnt", issue_count, 8);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_drained", exp_q.size(), 0);

    // Write accepted while popping a full queue
    do_reset();
    for (int k = 0; k < 8; k++) write_word(20'h40000 + 20'(k), 1'b1);
    load_done = 1'b1;
    pulse_start();
    write_word(20'hFFFFF, 1'b1);
    chk("wpop_ovf", overflow, 0);
    chk("wpop_full", full, 1);
    wait_done("wpop");
    chk("wpop_cnt", issue_count, 9);
    chk("wpop_drained", exp_q.size(), 0);

    // Reset mid-run
    do_reset();
    for (int k = 0; k < 5; k++) write_word(20'h50000 + 20'(k), 1'b1);
    pulse_start();
    tick();
    tick();
    chk("mid_cnt2", issue_count, 2);
    do_reset();
    chk("mid_data", data, 20'h00000);
    chk("mid_valid", data_valid, 0);
    chk("mid_cnt", issue_count, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_full", full, 0);
    tick();
    chk("mid_idle", busy, 0);
    load_done = 1'b1;
    pulse_start();
    chk("mid_run", busy, 1);
    tick();
    chk("mid_to_done", done, 1);
    chk("mid_nocnt", issue_count, 0);
    tick();
    chk("mid_novalid", data_valid, 0);

    // Restart from DONE
    do_reset();
    write_word(20'h60001, 1'b1);
    load_done = 1'b1;
    pulse_start();
    wait_done("rs1");
    chk("rs_cnt1", issue_count, 1);
    write_word(20'h6AAAA, 1'b1);
    write_word(20'h6BBBB, 1'b1);
    chk("rs_still_done", done, 1);
    chk("rs_hold_nop", data_valid, 0);
    pulse_start();
    chk("rs_busy", busy, 1);
    chk("rs_not_done", done, 0);
    chk("rs_cnt0", issue_count, 0);
    tick(); chk("rs_w0", data, 20'h6AAAA); chk("rs_c1", issue_count, 1);
    tick(); chk("rs_w1", data, 20'h6BBBB); chk("rs_c2", issue_count, 2);
    wait_done("rs2");
    chk("rs_cnt_end", issue_count, 2);
    chk("rs_drained", exp_q.size(), 0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
